// File: rtl/pe_pkg.sv
// Shared widths, defaults and lane helpers for the PE dot/accumulate block.
// Pure definitions: no state, no latency, no backpressure.
package pe_types;

  localparam int FEATURE_WIDTH_DEF     = 5;
  localparam int FILTER_WIDTH_DEF      = 5;
  localparam int DOT_SIZE_DEF          = 8;
  localparam int MULT_OUTPUT_WIDTH_DEF = 9;
  localparam int DOT_OUTPUT_WIDTH_DEF  = 12;
  localparam int DOT_LATENCY_DEF       = 5;
  localparam int ACCUM_WIDTH_DEF       = 16;

  localparam int LANE_MAX   = 16;
  localparam int LANE_IDX_W = $clog2(LANE_MAX);

  // Sign-extends a width-bit lane and folds the most negative code onto its
  // neighbour so every operand magnitude is representable after negation.
  function automatic logic signed [LANE_MAX-1:0] unpack_lane(
    input logic [LANE_MAX-1:0] raw,
    input int                  width
  );
    logic signed [LANE_MAX-1:0] ext;
    int                         v;
    int                         lo;
    for (int b = 0; b < LANE_MAX; b++) begin
      ext[LANE_IDX_W'(b)] = (b < width) ? raw[LANE_IDX_W'(b)] : raw[LANE_IDX_W'(width - 1)];
    end
    v  = int'(ext);
    lo = -(1 << (width - 1));
    if (v == lo) begin
      v = lo + 1;
    end
    return LANE_MAX'(v);
  endfunction

endpackage

// File: rtl/pe_if.sv
// Beat input and result output bundle of the PE.
// Plain valid strobes in both directions; there is no backpressure path.
interface pe_if
  import pe_types::*;
#(
  parameter int DOT_SIZE          = DOT_SIZE_DEF,
  parameter int FEATURE_WIDTH     = FEATURE_WIDTH_DEF,
  parameter int FILTER_WIDTH      = FILTER_WIDTH_DEF,
  parameter int FIXED_ACCUM_WIDTH = ACCUM_WIDTH_DEF
);

  logic                                i_valid;
  logic                                i_first;
  logic                                i_last;
  logic [DOT_SIZE*FEATURE_WIDTH-1:0]   i_features;
  logic [DOT_SIZE*FILTER_WIDTH-1:0]    i_filter;
  logic                                o_valid;
  logic signed [FIXED_ACCUM_WIDTH-1:0] o_result;

  modport master (
    output i_valid, i_first, i_last, i_features, i_filter,
    input  o_valid, o_result
  );

  modport slave (
    input  i_valid, i_first, i_last, i_features, i_filter,
    output o_valid, o_result
  );

endinterface

// File: rtl/pe_dot.sv
// Clamped signed lane multiply and adder chain, DOT_LATENCY register stages deep.
// Flags ride alongside the dot; no backpressure, one beat per clock.
module pe_dot
  import pe_types::*;
#(
  parameter int FEATURE_WIDTH     = FEATURE_WIDTH_DEF,
  parameter int FILTER_WIDTH      = FILTER_WIDTH_DEF,
  parameter int DOT_SIZE          = DOT_SIZE_DEF,
  parameter int MULT_OUTPUT_WIDTH = MULT_OUTPUT_WIDTH_DEF,
  parameter int DOT_OUTPUT_WIDTH  = DOT_OUTPUT_WIDTH_DEF,
  parameter int DOT_LATENCY       = DOT_LATENCY_DEF
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               in_valid,
  input  logic                               in_first,
  input  logic                               in_last,
  input  logic [DOT_SIZE*FEATURE_WIDTH-1:0]  features,
  input  logic [DOT_SIZE*FILTER_WIDTH-1:0]   filter,
  output logic                               out_valid,
  output logic                               out_first,
  output logic                               out_last,
  output logic signed [DOT_OUTPUT_WIDTH-1:0] dot
);

  localparam int NST = DOT_LATENCY - 1;

  logic signed [MULT_OUTPUT_WIDTH-1:0] prod_q [DOT_SIZE];
  logic signed [DOT_OUTPUT_WIDTH-1:0]  psum   [DOT_SIZE+1];
  logic                                p_vld, p_first, p_last;

  logic signed [DOT_OUTPUT_WIDTH-1:0]  st_dot   [NST];
  logic                                st_vld   [NST];
  logic                                st_first [NST];
  logic                                st_last  [NST];

  assign psum[0] = '0;

  for (genvar k = 0; k < DOT_SIZE; k++) begin : g_lane
    logic signed [LANE_MAX-1:0] fa, fb;
    assign fa = unpack_lane(LANE_MAX'(features[k*FEATURE_WIDTH +: FEATURE_WIDTH]), FEATURE_WIDTH);
    assign fb = unpack_lane(LANE_MAX'(filter[k*FILTER_WIDTH +: FILTER_WIDTH]), FILTER_WIDTH);

    always_ff @(posedge clock) begin
      prod_q[k] <= MULT_OUTPUT_WIDTH'(fa * fb);
    end

    assign psum[k+1] = psum[k] + DOT_OUTPUT_WIDTH'(prod_q[k]);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      p_vld <= 1'b0;
    end else begin
      p_vld <= in_valid;
    end
    p_first <= in_first;
    p_last  <= in_last;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      st_vld[0] <= 1'b0;
    end else begin
      st_vld[0] <= p_vld;
    end
    st_dot[0]   <= psum[DOT_SIZE];
    st_first[0] <= p_first;
    st_last[0]  <= p_last;
  end

  // Remaining stages are pure delay so the dot emerges DOT_LATENCY clocks after its beat.
  for (genvar s = 1; s < NST; s++) begin : g_stage
    always_ff @(posedge clock) begin
      if (reset) begin
        st_vld[s] <= 1'b0;
      end else begin
        st_vld[s] <= st_vld[s-1];
      end
      st_dot[s]   <= st_dot[s-1];
      st_first[s] <= st_first[s-1];
      st_last[s]  <= st_last[s-1];
    end
  end

  assign out_valid = st_vld[NST-1];
  assign out_first = st_first[NST-1];
  assign out_last  = st_last[NST-1];
  assign dot       = st_dot[NST-1];

endmodule

// File: rtl/pe.sv
// Processing element: pipelined dot product feeding a saturating accumulator.
// Result strobes DOT_LATENCY+1 clocks after the last beat; no backpressure.
module pe
  import pe_types::*;
#(
  parameter int FEATURE_WIDTH     = FEATURE_WIDTH_DEF,
  parameter int FILTER_WIDTH      = FILTER_WIDTH_DEF,
  parameter int DOT_SIZE          = DOT_SIZE_DEF,
  parameter int MULT_OUTPUT_WIDTH = MULT_OUTPUT_WIDTH_DEF,
  parameter int DOT_OUTPUT_WIDTH  = DOT_OUTPUT_WIDTH_DEF,
  parameter int DOT_LATENCY       = DOT_LATENCY_DEF,
  parameter int FIXED_ACCUM_WIDTH = ACCUM_WIDTH_DEF,
  parameter int PE_ID             = 0,
  parameter int CHAIN_ID          = 0,
  parameter int USE_ALM_DOT       = 1,
  parameter int USE_ALM_ACCUM     = 1
) (
  input logic  clock,
  input logic  reset,
  pe_if.slave  bus
);

  localparam int AW = FIXED_ACCUM_WIDTH;

  if (DOT_LATENCY < 2 || FEATURE_WIDTH > LANE_MAX || FILTER_WIDTH > LANE_MAX ||
      PE_ID < 0 || CHAIN_ID < 0 || USE_ALM_DOT > 1 || USE_ALM_ACCUM > 1) begin : g_bad_params
    $error("pe: unsupported parameter combination");
  end

  logic                               dot_vld, dot_first, dot_last;
  logic signed [DOT_OUTPUT_WIDTH-1:0] dot;
  logic signed [AW-1:0]               acc_q, base, acc_next;
  logic signed [AW:0]                 sum_wide;

  pe_dot #(
    .FEATURE_WIDTH     (FEATURE_WIDTH),
    .FILTER_WIDTH      (FILTER_WIDTH),
    .DOT_SIZE          (DOT_SIZE),
    .MULT_OUTPUT_WIDTH (MULT_OUTPUT_WIDTH),
    .DOT_OUTPUT_WIDTH  (DOT_OUTPUT_WIDTH),
    .DOT_LATENCY       (DOT_LATENCY)
  ) u_dot (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (bus.i_valid),
    .in_first  (bus.i_first),
    .in_last   (bus.i_last),
    .features  (bus.i_features),
    .filter    (bus.i_filter),
    .out_valid (dot_vld),
    .out_first (dot_first),
    .out_last  (dot_last),
    .dot       (dot)
  );

  // One guard bit catches overflow; a pinned rail naturally stays pinned
  // until an add of the opposite sign pulls it back in range.
  always_comb begin
    base     = dot_first ? '0 : acc_q;
    sum_wide = (AW+1)'(base) + (AW+1)'(dot);
    acc_next = sum_wide[AW-1:0];
    if (sum_wide[AW] != sum_wide[AW-1]) begin
      acc_next = sum_wide[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q        <= '0;
      bus.o_valid  <= 1'b0;
      bus.o_result <= '0;
    end else begin
      bus.o_valid <= dot_vld & dot_last;
      if (dot_vld) begin
        acc_q <= acc_next;
        if (dot_last) begin
          bus.o_result <= acc_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_pe.sv
// Directed-vector bench for pe: stimulus pushes hand-computed results into a
// scoreboard queue, a negedge monitor pops and checks value and latency.
module tb_pe;

  localparam int FW   = 5;
  localparam int DS   = 8;
  localparam int ACCW = 16;
  localparam int LAT  = 6;

  typedef struct {
    int res;
    int cyc;
    int tag;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  pe_if #(.DOT_SIZE(DS), .FEATURE_WIDTH(FW), .FILTER_WIDTH(FW), .FIXED_ACCUM_WIDTH(ACCW)) bus ();

  pe dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [DS*FW-1:0] fill(input int v);
    logic [FW-1:0] l;
    l = FW'(v);
    return {DS{l}};
  endfunction

  task automatic chk(input string nm, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask

  // Drives a beat at the current instant; caller is already at a negedge.
  task automatic beat_now(input logic [DS*FW-1:0] f, input logic [DS*FW-1:0] w,
                          input logic first, input logic last,
                          input bit push, input int exp_res, input int tag);
    bus.i_valid    = 1'b1;
    bus.i_first    = first;
    bus.i_last     = last;
    bus.i_features = f;
    bus.i_filter   = w;
    if (push) sb.push_back('{exp_res, cyc, tag});
  endtask

  task automatic beat(input int f, input int w, input logic first, input logic last,
                      input bit push, input int exp_res, input int tag);
    @(negedge clock);
    beat_now(fill(f), fill(w), first, last, push, exp_res, tag);
  endtask

  // Invalid beats carry junk flags and data that must be ignored.
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      bus.i_valid    = 1'b0;
      bus.i_first    = 1'b1;
      bus.i_last     = 1'b1;
      bus.i_features = fill(-16);
      bus.i_filter   = fill(15);
    end
  endtask

  task automatic drain(input int tag);
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout tag %0d: %0d results outstanding, want 0", tag, sb.size());
      sb.delete();
    end
    idle(2);
  endtask

  always @(negedge clock) begin
    if (bus.o_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_o_valid: got result %0d at cycle %0d, want no pulse", int'(bus.o_result), cyc);
      end else begin
        mon_e = sb.pop_front();
        n_cmp++;
        if (int'(bus.o_result) != mon_e.res) begin
          n_bad++;
          $display("FAIL result tag %0d: got %0d, want %0d", mon_e.tag, int'(bus.o_result), mon_e.res);
        end
        n_cmp++;
        if (cyc - mon_e.cyc != LAT) begin
          n_bad++;
          $display("FAIL latency tag %0d: got %0d, want %0d", mon_e.tag, cyc - mon_e.cyc, LAT);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.i_valid    = 1'b0;
    bus.i_first    = 1'b0;
    bus.i_last     = 1'b0;
    bus.i_features = '0;
    bus.i_filter   = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_o_valid", int'(bus.o_valid), 0);
    chk("reset_o_result", int'(bus.o_result), 0);
    reset = 1'b0;

    // Three 1x1 beats with ignored bubbles between them: 3*8 = 24
    beat(1, 1, 1'b1, 1'b0, 0, 0, 1);
    idle(1);
    beat(1, 1, 1'b0, 1'b0, 0, 0, 1);
    idle(2);
    beat(1, 1, 1'b0, 1'b1, 1, 24, 1);
    idle(1);
    drain(1);

    // Single beat -3*5 over 8 lanes
    beat(-3, 5, 1'b1, 1'b1, 1, -120, 2);
    idle(1);
    drain(2);

    // 19 x 1800 pins at +32767; a following -1800 leaves the rail
    for (int i = 0; i < 19; i++) begin
      beat(15, 15, i == 0, i == 18, i == 18, 32767, 3);
    end
    beat(15, -15, 1'b0, 1'b1, 1, 30967, 4);
    idle(1);
    drain(3);

    // 19 x -1800 pins at -32768
    for (int i = 0; i < 19; i++) begin
      beat(15, -15, i == 0, i == 18, i == 18, -32768, 5);
    end
    idle(1);
    drain(5);

    // -16 clamps to -15 on both sides: 225*8, then a continuation beat adds 8
    beat(-16, -16, 1'b1, 1'b1, 1, 1800, 6);
    beat(1, 1, 1'b0, 1'b1, 1, 1808, 7);
    idle(1);
    drain(6);

    // Lane0 7*-2 then an immediately following group of 1x1
    @(negedge clock);
    beat_now({{(DS-1)*FW{1'b0}}, 5'd7}, {{(DS-1)*FW{1'b0}}, 5'b11110}, 1'b1, 1'b1, 1, -14, 8);
    beat(1, 1, 1'b1, 1'b1, 1, 8, 9);
    idle(1);
    drain(8);
    idle(5);
    chk("hold_o_result", int'(bus.o_result), 8);

    // Beat killed by reset three cycles later; first post-reset beat accumulates on 0
    beat(2, 2, 1'b1, 1'b1, 0, 0, 10);
    idle(2);
    @(negedge clock);
    reset       = 1'b1;
    bus.i_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("inreset_o_valid", int'(bus.o_valid), 0);
    chk("inreset_o_result", int'(bus.o_result), 0);
    reset = 1'b0;
    beat_now(fill(1), fill(1), 1'b0, 1'b1, 1, 8, 11);
    idle(1);
    drain(11);
    chk("post_reset_o_result", int'(bus.o_result), 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pe.md
PE -- requirements
Module: pe

Interface
REQ-001 Parameters, default, meaning:
- FEATURE_WIDTH, 5: signed feature mantissa bits.
- FILTER_WIDTH, 5: signed filter mantissa bits.
- DOT_SIZE, 8: lanes per dot.
- MULT_OUTPUT_WIDTH, 9: lane product bits.
- DOT_OUTPUT_WIDTH, 12: dot sum bits.
- DOT_LATENCY, 5: dot pipeline depth.
- FIXED_ACCUM_WIDTH, 16: accumulator bits.
- PE_ID, 0: PE index, informational.
- CHAIN_ID, 0: chain index, informational.
- USE_ALM_DOT, 1: implementation hint only, no functional effect.
- USE_ALM_ACCUM, 1: implementation hint only, no functional effect.

REQ-002 Ports, name, direction, width, meaning:
- clock, in, 1: single clock, rising edge.
- reset, in, 1: synchronous, active-high.
- i_valid, in, 1: input beat valid.
- i_first, in, 1: beat starts a new accumulation.
- i_last, in, 1: beat ends the accumulation.
- i_features, in, DOT_SIZE*FEATURE_WIDTH: lane k at bits [k*FW +: FW].
- i_filter, in, DOT_SIZE*FILTER_WIDTH: same lane packing.
- o_valid, out, 1: result strobe.
- o_result, out, FIXED_ACCUM_WIDTH: signed accumulated result.

Function
REQ-003 The block SHALL treat each lane operand as two's complement; an input of -16 SHALL be clamped to -15 before multiplying.
REQ-004 The block SHALL compute dot = sum over k of feature[k]*filter[k], exact, as a DOT_OUTPUT_WIDTH signed value (max |dot| 1800, so no overflow).
REQ-005 The dot SHALL be registered through DOT_LATENCY stages; the valid, first and last flags SHALL travel alongside it.
REQ-006 On a dot-valid beat with first=1, acc SHALL be set to sign-extended dot; with first=0, acc SHALL be set to acc+dot.
REQ-007 Accumulation SHALL saturate to [-32768, 32767]; a saturated acc SHALL stay saturated until further adds bring it back in range or first=1.
REQ-008 Beats with i_valid=0 SHALL be ignored; i_first and i_last SHALL be don't-care when i_valid=0.
REQ-009 On a valid beat with last=1, o_valid SHALL pulse for one cycle and o_result SHALL equal the final acc.
REQ-010 The total latency from an input beat with i_last to o_valid SHALL be DOT_LATENCY+1 = 6 cycles.
REQ-011 o_result SHALL hold its value between pulses.
REQ-012 first=1 and last=1 on the same beat SHALL output that beat's dot alone.
REQ-013 A valid beat with no preceding first SHALL accumulate onto the current acc (0 after reset).
REQ-014 Back-to-back groups (last immediately followed by first) SHALL be supported with no bubble.

Reset
REQ-015 While reset=1, all pipeline valid bits, acc, o_valid and o_result SHALL be cleared to 0 at the next clock edge.
REQ-016 Beats in flight during reset SHALL be discarded and SHALL produce no o_valid.
REQ-017 Inputs SHALL be accepted on the first edge after reset deasserts.

Structure
REQ-018 Widths, defaults and the lane-unpack function SHALL reside in a shared package pe_types.
REQ-019 The multiply and adder-tree pipeline SHALL be the sub-module pe_dot.
REQ-020 The accumulator SHALL be inline logic in pe.

Verification
REQ-021 All lanes 1×1, three beats first..last -> o_valid 6 cycles after the last beat, o_result=24.
REQ-022 All lanes feature -3 × filter 5, single beat with first=last=1 -> o_result=-120.
REQ-023 All lanes 15×15 for 19 beats -> o_result=32767 (saturated).
REQ-024 All lanes -16×-16, single beat -> o_result=1800 (clamp check).
REQ-025 Lane0 7×-2, other lanes 0, then an immediate second group of lanes 1×1 -> consecutive results -14 then 8, no bubble.
REQ-026 Reset asserted 3 cycles after a last beat -> no o_valid, o_result=0.
